// File: rtl/mor1kx_branch_resolve.sv
// Holds the one conditional branch sitting between decode and execute, resolves it,
// raises a held fetch redirect on a mispredict and keeps saturating branch statistics.
module mor1kx_branch_resolve #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic                            decode_op_bf_i,
    input  logic                            decode_op_bnf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
    input  logic [25:0]                     decode_immjbr_i,
    input  logic                            predicted_flag_i,
    input  logic                            padv_execute_i,
    input  logic                            flag_i,
    input  logic                            branch_mispredict_i,
    input  logic                            pipeline_flush_i,
    input  logic                            redirect_ack_i,
    output logic                            ex_brcond_o,
    output logic                            ex_predicted_flag_o,
    output logic                            redirect_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    output logic [CNT_WIDTH-1:0]            branch_cnt_o,
    output logic [CNT_WIDTH-1:0]            mispredict_cnt_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic           ex_valid_reg, ex_valid_next;
    logic           ex_bf_reg, ex_bnf_reg, ex_pred_reg;
    logic [W-1:0]   ex_target_reg, ex_fallthru_reg;
    logic [W-1:0]   redirect_pc_reg, redirect_pc_next;

    logic           resolve;
    logic           mispredict;
    logic           capture;
    logic           taken;
    logic [W-1:0]   branch_offset;

    // A flush cancels everything in flight, including a resolve in the same cycle.
    assign resolve       = ex_valid_reg & padv_execute_i & ~pipeline_flush_i;
    assign mispredict    = resolve & branch_mispredict_i;
    // Decode is on the wrong path while redirecting or when the older branch mispredicts.
    assign capture       = (state_reg == S_IDLE) & padv_decode_i & ~pipeline_flush_i & ~mispredict;
    assign taken         = (ex_bf_reg & flag_i) | (ex_bnf_reg & ~flag_i);
    assign branch_offset = W'($signed({decode_immjbr_i, 2'b00}));

    always_comb begin
        state_next       = state_reg;
        ex_valid_next    = ex_valid_reg;
        redirect_pc_next = redirect_pc_reg;
        if (pipeline_flush_i) begin
            state_next    = S_IDLE;
            ex_valid_next = 1'b0;
        end else begin
            if (capture)
                ex_valid_next = decode_op_bf_i | decode_op_bnf_i;
            else if (resolve)
                ex_valid_next = 1'b0;

            if (mispredict) begin
                state_next       = S_REDIRECT;
                redirect_pc_next = taken ? ex_target_reg : ex_fallthru_reg;
            end else if ((state_reg == S_REDIRECT) && redirect_ack_i) begin
                state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            ex_valid_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            state_reg       <= state_next;
            ex_valid_reg    <= ex_valid_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    // Payload only matters while ex_valid_reg is set, so it loads on any capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_bf_reg       <= 1'b0;
            ex_bnf_reg      <= 1'b0;
            ex_pred_reg     <= 1'b0;
            ex_target_reg   <= '0;
            ex_fallthru_reg <= '0;
        end else if (capture) begin
            ex_bf_reg       <= decode_op_bf_i;
            ex_bnf_reg      <= decode_op_bnf_i;
            ex_pred_reg     <= predicted_flag_i;
            ex_target_reg   <= decode_pc_i + branch_offset;
            ex_fallthru_reg <= decode_pc_i + W'(8);
        end
    end

    // Index 0 counts resolved branches, index 1 counts mispredicts.
    logic [1:0]                cnt_inc;
    logic [1:0][CNT_WIDTH-1:0] cnt_val;

    assign cnt_inc = {mispredict, resolve};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cnt_reg <= '0;
                else if (cnt_inc[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign ex_brcond_o         = ex_valid_reg;
    assign ex_predicted_flag_o = ex_valid_reg & ex_pred_reg;
    assign redirect_o          = (state_reg == S_REDIRECT);
    assign redirect_pc_o       = redirect_pc_reg;
    assign branch_cnt_o        = cnt_val[0];
    assign mispredict_cnt_o    = cnt_val[1];

endmodule
